// File: rtl/fx_stage_driver.sv
// Initiator side of an effect stage start/done handshake: hands one sample to the
// stage, holds start until done or timeout, then emits the result with a valid pulse.
module fx_stage_driver #(
  parameter int unsigned WIDTH          = 12,
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned CNT_W          = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             sample_ready,
  input  logic [WIDTH-1:0] sample_in,
  output logic             fx_start,
  output logic [WIDTH-1:0] fx_sample,
  input  logic [WIDTH-1:0] fx_result,
  input  logic             fx_done,
  output logic [WIDTH-1:0] sample_out,
  output logic             sample_valid,
  output logic             busy,
  output logic             timeout_pulse,
  output logic             overrun_pulse,
  output logic [CNT_W-1:0] timeout_count,
  output logic [CNT_W-1:0] overrun_count
);

  localparam int unsigned TMR_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARM,
    ST_WAIT
  } state_t;

  state_t             r_state;
  logic [TMR_W-1:0]   r_timer;
  logic [WIDTH-1:0]   r_raw;
  logic               r_fx_start;
  logic [WIDTH-1:0]   r_fx_sample;
  logic [WIDTH-1:0]   r_sample_out;
  logic               r_sample_valid;
  logic               r_busy;
  logic               r_timeout_pulse;
  logic               r_overrun_pulse;
  logic [CNT_W-1:0]   r_timeout_count;
  logic [CNT_W-1:0]   r_overrun_count;

  // Handshake FSM; pulses default low every cycle, counters saturate.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state         <= ST_IDLE;
      r_timer         <= '0;
      r_raw           <= '0;
      r_fx_start      <= 1'b0;
      r_fx_sample     <= '0;
      r_sample_out    <= '0;
      r_sample_valid  <= 1'b0;
      r_busy          <= 1'b0;
      r_timeout_pulse <= 1'b0;
      r_overrun_pulse <= 1'b0;
      r_timeout_count <= '0;
      r_overrun_count <= '0;
    end else begin
      r_sample_valid  <= 1'b0;
      r_timeout_pulse <= 1'b0;
      r_overrun_pulse <= 1'b0;

      // A strobe outside IDLE (including the completing edge) is dropped.
      if (sample_ready && (r_state != ST_IDLE)) begin
        r_overrun_pulse <= 1'b1;
        if (r_overrun_count != CNT_MAX) r_overrun_count <= r_overrun_count + CNT_W'(1);
      end

      case (r_state)
        ST_IDLE: begin
          if (sample_ready) begin
            r_fx_sample <= sample_in;
            r_raw       <= sample_in;
            r_fx_start  <= 1'b1;
            r_busy      <= 1'b1;
            r_state     <= ST_ARM;
          end
        end
        // done may still be high from the previous sample here, so it is ignored.
        ST_ARM: begin
          r_timer <= '0;
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (fx_done) begin
            r_sample_out   <= fx_result;
            r_sample_valid <= 1'b1;
            r_fx_start     <= 1'b0;
            r_busy         <= 1'b0;
            r_state        <= ST_IDLE;
          end else if (r_timer == TMR_LAST) begin
            r_sample_out    <= r_raw;
            r_sample_valid  <= 1'b1;
            r_timeout_pulse <= 1'b1;
            if (r_timeout_count != CNT_MAX) r_timeout_count <= r_timeout_count + CNT_W'(1);
            r_fx_start      <= 1'b0;
            r_busy          <= 1'b0;
            r_state         <= ST_IDLE;
          end else begin
            r_timer <= r_timer + TMR_W'(1);
          end
        end
        default: begin
          r_fx_start <= 1'b0;
          r_busy     <= 1'b0;
          r_state    <= ST_IDLE;
        end
      endcase
    end
  end

  assign fx_start      = r_fx_start;
  assign fx_sample     = r_fx_sample;
  assign sample_out    = r_sample_out;
  assign sample_valid  = r_sample_valid;
  assign busy          = r_busy;
  assign timeout_pulse = r_timeout_pulse;
  assign overrun_pulse = r_overrun_pulse;
  assign timeout_count = r_timeout_count;
  assign overrun_count = r_overrun_count;

endmodule

// File: tb/tb_fx_stage_driver.sv
// Directed bench for fx_stage_driver with a small bitcrusher stage model that keeps done sticky.
module tb_fx_stage_driver;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        sample_ready = 1'b0;
  logic [11:0] sample_in = '0;
  logic        fx_start;
  logic [11:0] fx_sample;
  logic [11:0] fx_result;
  logic        fx_done;
  logic [11:0] sample_out;
  logic        sample_valid;
  logic        busy;
  logic        timeout_pulse;
  logic        overrun_pulse;
  logic [7:0]  timeout_count;
  logic [7:0]  overrun_count;

  int n_checks = 0;
  int n_fail   = 0;

  fx_stage_driver #(.WIDTH(12), .TIMEOUT_CYCLES(16), .CNT_W(8)) dut (
    .clock(clock), .reset(reset),
    .sample_ready(sample_ready), .sample_in(sample_in),
    .fx_start(fx_start), .fx_sample(fx_sample),
    .fx_result(fx_result), .fx_done(fx_done),
    .sample_out(sample_out), .sample_valid(sample_valid), .busy(busy),
    .timeout_pulse(timeout_pulse), .overrun_pulse(overrun_pulse),
    .timeout_count(timeout_count), .overrun_count(overrun_count)
  );

  always #5 clock = ~clock;

  // Effect stage: enable=0 answers one edge after start, enable=1 two edges
  // (bits=0 never answers); done stays high until the next start is seen.
  logic        fx_en   = 1'b0;
  int          fx_bits = 0;
  int          st      = 0;
  logic [11:0] m_in;
  logic [11:0] m_mask;
  assign m_mask = 12'hFFF << fx_bits;

  always @(posedge clock) begin
    if (reset) begin
      st <= 0; fx_done <= 1'b0; fx_result <= '0; m_in <= '0;
    end else begin
      case (st)
        0: if (fx_start) begin
          fx_done <= 1'b0;
          m_in    <= fx_sample;
          if (!fx_en) begin
            fx_done <= 1'b1; fx_result <= fx_sample; st <= 2;
          end else if (fx_bits == 0) st <= 3;
          else st <= 1;
        end
        1: begin fx_done <= 1'b1; fx_result <= m_in & m_mask; st <= 2; end
        default: if (!fx_start) st <= 0;
      endcase
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Strobe one sample; returns at the negedge after the accepting edge E0.
  task automatic strobe(input logic [11:0] s);
    @(negedge clock);
    sample_ready = 1'b1;
    sample_in    = s;
    @(posedge clock);
    @(negedge clock);
    sample_ready = 1'b0;
  endtask

  // Number of edges until sample_valid is seen (0 when the bound expires).
  task automatic wait_valid(output int n);
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clock);
      if (sample_valid) begin n = i; break; end
    end
  endtask

  int n;
  int pulses;

  initial begin
    repeat (3) @(negedge clock);
    check("rst_fx_start", 32'(fx_start), 32'd0);
    check("rst_valid", 32'(sample_valid), 32'd0);
    check("rst_out", 32'(sample_out), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_counts", {16'd0, timeout_count, overrun_count}, 32'd0);
    reset = 1'b0;

    // 1: bypass, result one edge after start
    fx_en = 1'b0;
    strobe(12'h123);
    check("t1_start", 32'(fx_start), 32'd1);
    check("t1_fx_sample", 32'(fx_sample), 32'h123);
    check("t1_busy", 32'(busy), 32'd1);
    wait_valid(n);
    check("t1_latency", 32'(n), 32'd2);
    check("t1_out", 32'(sample_out), 32'h123);
    check("t1_start_low", 32'(fx_start), 32'd0);
    @(negedge clock);
    check("t1_valid_pulse", 32'(sample_valid), 32'd0);
    check("t1_out_hold", 32'(sample_out), 32'h123);

    // 2: crush 3 bits
    fx_en = 1'b1; fx_bits = 3;
    strobe(12'h7FF);
    wait_valid(n);
    check("t2_latency", 32'(n), 32'd3);
    check("t2_out", 32'(sample_out), 32'h7F8);
    check("t2_start_low", 32'(fx_start), 32'd0);
    check("t2_busy", 32'(busy), 32'd0);

    // 3: stale done from test 2 must not be taken in ARM
    fx_bits = 2;
    strobe(12'hFFB);
    wait_valid(n);
    check("t3_latency", 32'(n), 32'd3);
    check("t3_out", 32'(sample_out), 32'hFF8);

    // 4: hung stage -> timeout bypass of raw sample
    fx_bits = 0;
    strobe(12'h055);
    wait_valid(n);
    check("t4_latency", 32'(n), 32'd17);
    check("t4_out", 32'(sample_out), 32'h055);
    check("t4_to_pulse", 32'(timeout_pulse), 32'd1);
    check("t4_to_count", 32'(timeout_count), 32'd1);
    @(negedge clock);
    check("t4_to_pulse_end", 32'(timeout_pulse), 32'd0);

    // 5: second strobe one cycle later is dropped
    fx_bits = 3;
    strobe(12'h100);
    sample_ready = 1'b1; sample_in = 12'h200;
    @(posedge clock);
    @(negedge clock);
    sample_ready = 1'b0;
    check("t5_ov_pulse", 32'(overrun_pulse), 32'd1);
    check("t5_ov_count", 32'(overrun_count), 32'd1);
    wait_valid(n);
    check("t5_latency", 32'(n), 32'd2);
    check("t5_out", 32'(sample_out), 32'h100);
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (sample_valid) pulses++;
    end
    check("t5_no_second", 32'(pulses), 32'd0);
    check("t5_ov_pulse_end", 32'(overrun_pulse), 32'd0);

    // 6: reset while waiting aborts the transaction
    fx_bits = 0;
    strobe(12'h3C3);
    repeat (4) @(negedge clock);
    check("t6_busy_pre", 32'(busy), 32'd1);
    reset = 1'b1;
    @(negedge clock);
    check("t6_start", 32'(fx_start), 32'd0);
    check("t6_valid", 32'(sample_valid), 32'd0);
    check("t6_counts", {16'd0, timeout_count, overrun_count}, 32'd0);
    reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (sample_valid) pulses++;
    end
    check("t6_no_aborted_valid", 32'(pulses), 32'd0);
    fx_en = 1'b0;
    strobe(12'h3A5);
    wait_valid(n);
    check("t6_latency", 32'(n), 32'd2);
    check("t6_out", 32'(sample_out), 32'h3A5);

    // Overrun counter saturates under a continuous strobe into a hung stage
    fx_en = 1'b1; fx_bits = 0;
    @(negedge clock);
    sample_ready = 1'b1; sample_in = 12'h0AA;
    repeat (600) @(negedge clock);
    sample_ready = 1'b0;
    check("sat_ov_count", 32'(overrun_count), 32'hFF);
    check("sat_to_nonzero", 32'(timeout_count != 8'd0), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
